// File: rtl/mem_pkg.sv
// Shared types and constants for the memory test transaction initiator.
package mem_pkg;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefTimeout   = 16;

    // Request direction encoding on wr_rd_o.
    localparam logic Wr = 1'b1;
    localparam logic Rd = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrGap,
        StRdReq,
        StRdGap,
        StFin
    } state_e;

endpackage

// File: rtl/mem_pattern_chk.sv
// Address/data pattern generator and read-data comparator.
module mem_pattern_chk
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [WIDTH-1:0]      seed_i,
    input  logic [ADDR_WIDTH:0]   idx_i,
    input  logic [WIDTH-1:0]      exp_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  mismatch_o
);

    localparam int unsigned SumW = (WIDTH > ADDR_WIDTH + 1) ? WIDTH : ADDR_WIDTH + 1;

    // Pattern for location idx: both sums wrap modulo their bus width.
    always_comb begin
        addr_o = ADDR_WIDTH'(SumW'(base_i) + SumW'(idx_i));
        data_o = WIDTH'(SumW'(seed_i) + SumW'(idx_i));
    end

    // Kept separate from the generator so the compare path has no dependency on idx.
    always_comb begin
        mismatch_o = (rdata_i != exp_i);
    end

endmodule

// File: rtl/mem_txn_initiator.sv
// Memory test initiator: writes a seeded pattern over an address range, reads it back
// and reports mismatches, with a per-request ready timeout.
module mem_txn_initiator
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [7:0]            err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam int unsigned        WaitW    = $clog2(TIMEOUT + 1);
    // done_o is registered out of FIN, so aborting here puts done_o TIMEOUT cycles after valid rose.
    localparam logic [WaitW-1:0]   WaitLast = WaitW'(TIMEOUT - 2);
    localparam logic [WaitW-1:0]   WaitOne  = WaitW'(1);
    localparam logic [ADDR_WIDTH:0] IdxOne  = (ADDR_WIDTH + 1)'(1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [WIDTH-1:0]       seed_q, seed_d;
    logic [ADDR_WIDTH:0]    idx_q, idx_d;
    logic [WaitW-1:0]       wait_q, wait_d;
    logic [7:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]  first_q, first_d;
    logic                   pass_q, pass_d;
    logic                   tmo_q, tmo_d;
    logic                   done_q, done_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]       wdata_q, wdata_d;
    logic                   wr_rd_q, wr_rd_d;

    logic [ADDR_WIDTH-1:0]  gen_addr;
    logic [WIDTH-1:0]       gen_data;
    logic                   mismatch;
    logic                   last_idx;

    assign last_idx = (idx_q == count_q - IdxOne);

    mem_pattern_chk #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pattern_chk (
        .base_i     (base_d),
        .seed_i     (seed_d),
        .idx_i      (idx_d),
        .exp_i      (wdata_q),
        .rdata_i    (rdata_i),
        .addr_o     (gen_addr),
        .data_o     (gen_data),
        .mismatch_o (mismatch)
    );

    // Run sequencing: write phase, read-back phase, result reporting.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    count_d = count_i;
                    seed_d  = seed_i;
                    idx_d   = '0;
                    wait_d  = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = (count_i == '0) ? StFin : StWrReq;
                end
            end
            StWrReq: begin
                if (ready_i) begin
                    idx_d   = last_idx ? '0 : idx_q + IdxOne;
                    state_d = StWrGap;
                end else if (wait_q == WaitLast) begin
                    tmo_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    wait_d = wait_q + WaitOne;
                end
            end
            StWrGap: begin
                // idx only returns to 0 after the last write.
                wait_d  = '0;
                state_d = (idx_q == '0) ? StRdReq : StWrReq;
            end
            StRdReq: begin
                if (ready_i) begin
                    if (mismatch) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (err_q == 8'd0) begin
                            first_d = addr_q;
                        end
                    end
                    if (last_idx) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        state_d = StRdGap;
                    end
                end else if (wait_q == WaitLast) begin
                    tmo_d   = 1'b1;
                    state_d = StFin;
                end else begin
                    wait_d = wait_q + WaitOne;
                end
            end
            StRdGap: begin
                wait_d  = '0;
                state_d = StRdReq;
            end
            StFin: begin
                done_d  = 1'b1;
                pass_d  = (err_q == 8'd0) && !tmo_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request fields reload on entry to a request state and so stay stable while waiting.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_rd_d = wr_rd_q;
        if (state_d == StWrReq || state_d == StRdReq) begin
            addr_d  = gen_addr;
            wdata_d = gen_data;
            wr_rd_d = (state_d == StWrReq) ? Wr : Rd;
        end
    end

    // State and datapath registers; reset clears everything so every output reads 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            base_q  <= '0;
            count_q <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_rd_q <= wr_rd_d;
        end
    end

    assign valid_o          = (state_q == StWrReq) || (state_q == StRdReq);
    assign busy_o           = (state_q != StIdle);
    assign wr_rd_o          = wr_rd_q;
    assign addr_o           = addr_q;
    assign wdata_o          = wdata_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = tmo_q;
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_txn_initiator.sv
// Randomized bench for mem_txn_initiator against a transaction-level reference model.
module tb_mem_txn_initiator;

    localparam int TO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] base_addr_i = '0;
    logic [8:0] count_i = '0;
    logic [7:0] seed_i = '0;
    logic       valid_o, wr_rd_o;
    logic [7:0] addr_o, wdata_o;
    logic       ready_i = 1'b0;
    logic [7:0] rdata_i = '0;
    logic       busy_o, done_o, pass_o, timeout_o;
    logic [7:0] err_cnt_o, first_err_addr_o;

    mem_txn_initiator #(
        .WIDTH      (8),
        .ADDR_WIDTH (8),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .count_i          (count_i),
        .seed_i           (seed_i),
        .valid_o          (valid_o),
        .wr_rd_o          (wr_rd_o),
        .addr_o           (addr_o),
        .wdata_o          (wdata_o),
        .ready_i          (ready_i),
        .rdata_i          (rdata_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .timeout_o        (timeout_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        int         rise;
        int         hs;
    } txn_t;

    txn_t       txn_q[$];
    logic [7:0] mem [256];
    bit         corrupt [256];

    int n_checks = 0;
    int n_fail = 0;

    // Responder / monitor state
    int         lat_mode = 1;    // -1: never ready, 0..3: fixed latency, 4: random per request
    int         vcyc = 0;
    int         cur_lat = 0;
    int         cur_rise = 0;
    int         first_rise = -1;
    int         n_valid = 0;
    int         stab_bad = 0;
    logic [16:0] prev_fields = '0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    logic       d_pass = 1'b0, d_tmo = 1'b0;
    logic [7:0] d_err = '0, d_first = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model responder plus transaction recorder, evaluated mid-cycle.
    task automatic monitor_step();
        if (rst_i) begin
            vcyc = 0;
            ready_i = 1'b0;
        end else if (valid_o) begin
            vcyc++;
            if (vcyc == 1) begin
                cur_rise = cyc;
                n_valid++;
                if (first_rise < 0) first_rise = cyc;
                cur_lat = (lat_mode == 4) ? int'($urandom_range(0, 3)) : lat_mode;
            end else if ({wr_rd_o, addr_o, wdata_o} != prev_fields) begin
                stab_bad++;
            end
            prev_fields = {wr_rd_o, addr_o, wdata_o};
            ready_i = (lat_mode >= 0) && (vcyc > cur_lat);
            if (ready_i) begin
                if (wr_rd_o) begin
                    mem[addr_o] = wdata_o;
                    rdata_i = 8'($urandom);
                end else begin
                    rdata_i = mem[addr_o] ^ (corrupt[addr_o] ? 8'h5A : 8'h00);
                end
                txn_q.push_back('{wr_rd_o, addr_o, wr_rd_o ? wdata_o : rdata_i, cur_rise, cyc});
            end else begin
                rdata_i = 8'($urandom);
            end
        end else begin
            vcyc = 0;
            ready_i = 1'b0;
            rdata_i = 8'($urandom);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            d_pass  = pass_o;
            d_tmo   = timeout_o;
            d_err   = err_cnt_o;
            d_first = first_err_addr_o;
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        monitor_step();
    end

    // mode 0: none, 1: single address, 2: all, 3: random ~1/8
    task automatic set_corrupt(input int mode, input logic [7:0] a);
        for (int i = 0; i < 256; i++) begin
            corrupt[i] = (mode == 2) || (mode == 1 && i == int'(a)) ||
                         (mode == 3 && $urandom_range(0, 7) == 0);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o, timeout_o,
                    err_cnt_o, first_err_addr_o});
    endfunction

    task automatic run(input string tag, input logic [7:0] base, input logic [8:0] cnt,
                       input logic [7:0] seed, input int lat, input bit noise, input bit exp_tmo);
        int         errs;
        int         exp_n;
        int         idx;
        logic [7:0] first;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       exp_pass;
        txn_q.delete();
        done_cnt = 0;
        stab_bad = 0;
        n_valid = 0;
        first_rise = -1;
        lat_mode = lat;
        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        count_i = cnt;
        seed_i = seed;
        start_cyc = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
            @(negedge clk_i);
            // start_i while busy must be ignored; never raised once the run is back in idle
            start_i = noise && busy_o && ($urandom_range(0, 1) == 1);
            if (noise) begin
                base_addr_i = 8'($urandom);
                count_i = 9'($urandom_range(1, 9));
                seed_i = 8'($urandom);
            end
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);

        check({tag, ".done_pulses"}, 64'(done_cnt), 64'(1));
        exp_n = exp_tmo ? 0 : 2 * int'(cnt);
        check({tag, ".txn_count"}, 64'(txn_q.size()), 64'(exp_n));
        errs = 0;
        first = '0;
        for (int k = 0; k < exp_n && k < txn_q.size(); k++) begin
            idx = (k < int'(cnt)) ? k : k - int'(cnt);
            ea = base + 8'(idx);
            ed = seed + 8'(idx);
            if (k < int'(cnt)) begin
                check({tag, ".wr"}, 64'({txn_q[k].wr, txn_q[k].addr, txn_q[k].data}),
                      64'({1'b1, ea, ed}));
            end else begin
                check({tag, ".rd"}, 64'({txn_q[k].wr, txn_q[k].addr}), 64'({1'b0, ea}));
                if (txn_q[k].data != ed) begin
                    if (errs == 0) first = ea;
                    errs++;
                end
            end
            if (k > 0) begin
                check({tag, ".gap"}, 64'(txn_q[k].rise - txn_q[k-1].hs), 64'(2));
            end
        end
        exp_pass = (errs == 0) && !exp_tmo;
        check({tag, ".stable"}, 64'(stab_bad), 64'(0));
        check({tag, ".err_cnt"}, 64'(d_err), 64'((errs > 255) ? 255 : errs));
        check({tag, ".first_err"}, 64'(d_first), 64'(first));
        check({tag, ".pass_at_done"}, 64'(d_pass), 64'(exp_pass));
        check({tag, ".timeout"}, 64'(d_tmo), 64'(exp_tmo));
        check({tag, ".pass_held"}, 64'(pass_o), 64'(exp_pass));
        check({tag, ".idle"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        set_corrupt(0, 8'h00);
        repeat (3) @(negedge clk_i);
        check("reset.outputs", all_outputs(), 64'(0));
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        run("basic", 8'h10, 9'd4, 8'hA5, 1, 1'b0, 1'b0);

        set_corrupt(1, 8'h12);
        run("mismatch", 8'h10, 9'd4, 8'hA5, 1, 1'b0, 1'b0);
        check("mismatch.first_is_12", 64'(d_first), 64'(8'h12));

        set_corrupt(0, 8'h00);
        run("wrap", 8'hFF, 9'd3, 8'h3C, 1, 1'b0, 1'b0);

        run("zero", 8'h40, 9'd0, 8'h11, 1, 1'b0, 1'b0);
        check("zero.no_valid", 64'(n_valid), 64'(0));
        check("zero.done_delay", 64'(done_cyc - start_cyc), 64'(2));

        run("timeout", 8'h20, 9'd5, 8'h77, -1, 1'b0, 1'b1);
        check("timeout.done_delay", 64'(done_cyc - first_rise), 64'(TO));

        set_corrupt(2, 8'h00);
        run("saturate", 8'($urandom), 9'd300, 8'($urandom), 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            set_corrupt((r % 2 == 0) ? 3 : 0, 8'h00);
            run("random", 8'($urandom), 9'($urandom_range(1, 24)), 8'($urandom), 4,
                (r >= 2), 1'b0);
        end

        // Reset in the middle of the read phase aborts with no done pulse.
        set_corrupt(0, 8'h00);
        txn_q.delete();
        done_cnt = 0;
        lat_mode = 1;
        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = 8'h80;
        count_i = 9'd8;
        seed_i = 8'h01;
        @(negedge clk_i);
        start_i = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk_i);
            found = valid_o && !wr_rd_o;
        end
        check("abort.read_phase_reached", 64'(found), 64'(1));
        #2 rst_i = 1'b1;
        #1 check("abort.outputs_zero", all_outputs(), 64'(0));
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("abort.no_done", 64'(done_cnt), 64'(0));
        check("abort.stays_idle", 64'({busy_o, valid_o}), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
